// File: rtl/cla_adder_pipe_pkg.sv
// rtl/cla_adder_pipe_pkg.sv - shared op encodings and slice sizing for the pipelined CLA adder
package cla_adder_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Carry-lookahead group size inside each slice.
  localparam int GROUP = 4;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_slice.sv
// rtl/cla_adder_pipe_slice.sv - combinational SEG-bit carry-lookahead slice
module cla_slice
  import cla_adder_pipe_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;
  logic           gacc;
  logic           pacc;
  logic           cg;

  assign g = a & b;
  assign p = a ^ b;

  // Each bit carry is expanded from its group's carry-in and the group-local
  // generate/propagate prefix; only group carries chain between groups.
  always_comb begin
    c    = '0;
    gacc = 1'b0;
    pacc = 1'b1;
    cg   = cin;
    for (int i = 0; i < SEG; i++) begin
      if (i % GROUP == 0) begin
        gacc = 1'b0;
        pacc = 1'b1;
        cg   = (i == 0) ? cin : c[i];
      end
      c[i]   = gacc | (pacc & cg);
      gacc   = g[i] | (p[i] & gacc);
      pacc   = pacc & p[i];
      c[i+1] = gacc | (pacc & cg);
    end
  end

  assign sum   = p ^ c[SEG-1:0];
  assign cout  = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - WIDTH-bit add/sub split into STAGES pipelined CLA slices with valid/ready
module cla_adder_pipe
  import cla_adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("cla_adder_pipe: WIDTH must be a positive multiple of STAGES");
  end

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            cy_q, cy_d;
  logic [STAGES-1:0]            msb_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic                         ovf_q, zero_q;
  logic                         en;

  // The whole pipe moves together; it only freezes when the output is stuck.
  assign en       = !vld_q[STAGES-1] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src, b_src, s_src;
    logic             c_src, v_src;
    logic [SEG-1:0]   seg_sum;

    if (k == 0) begin : g_first
      assign a_src = in_a;
      assign b_src = (in_sub == OP_SUB) ? ~in_b : in_b;
      assign c_src = (in_sub == OP_SUB) ? 1'b1 : in_cin;
      assign s_src = '0;
      assign v_src = in_valid;
    end else begin : g_next
      assign a_src = a_q[k-1];
      assign b_src = b_q[k-1];
      assign c_src = cy_q[k-1];
      assign s_src = sum_q[k-1];
      assign v_src = vld_q[k-1];
    end

    cla_slice #(.SEG(SEG)) u_slice (
      .a     (a_src[SEG-1:0]),
      .b     (b_src[SEG-1:0]),
      .cin   (c_src),
      .sum   (seg_sum),
      .cout  (cy_d[k]),
      .c_msb (msb_d[k])
    );

    // Unprocessed operand slices are shifted down so every stage reads bits [SEG-1:0].
    assign a_d[k]   = a_src >> SEG;
    assign b_d[k]   = b_src >> SEG;
    assign sum_d[k] = s_src | (WIDTH'(seg_sum) << (k * SEG));
    assign vld_d[k] = v_src;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      sum_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      vld_q  <= vld_d;
      cy_q   <= cy_d;
      sum_q  <= sum_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ovf_q  <= msb_d[STAGES-1] ^ cy_d[STAGES-1];
      zero_q <= ~|sum_d[STAGES-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = cy_q[STAGES-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - self-checking bench for cla_adder_pipe at 32/4, 16/1 and 64/8
module tb_cla_adder_pipe;

  localparam int NI = 3;

  typedef struct {
    logic [63:0] s;
    logic        co, ov, z;
  } res_t;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        co, ov, z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid [NI];
  logic        in_cin   [NI];
  logic        in_sub   [NI];
  logic        out_ready[NI];
  logic [63:0] in_a     [NI];
  logic [63:0] in_b     [NI];
  logic        in_ready_w [NI];
  logic        out_valid_w[NI];
  logic        cout_w     [NI];
  logic        ovf_w      [NI];
  logic        zero_w     [NI];
  logic        busy_w     [NI];
  logic [63:0] sum_w      [NI];
  logic [31:0] sum32;
  logic [15:0] sum16;
  logic [63:0] sum64;

  int n_vec = 0;
  int n_bad = 0;

  res_t        q[NI][$];
  int          rx_cnt    [NI];
  logic        stall_prev[NI];
  logic [63:0] prev_sum  [NI];
  logic [2:0]  prev_flg  [NI];

  always #5 clk = ~clk;

  assign sum_w[0] = {32'd0, sum32};
  assign sum_w[1] = {48'd0, sum16};
  assign sum_w[2] = sum64;

  cla_adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_a(in_a[0][31:0]), .in_b(in_b[0][31:0]), .in_cin(in_cin[0]), .in_sub(in_sub[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .out_sum(sum32),
    .out_cout(cout_w[0]), .out_ovf(ovf_w[0]), .out_zero(zero_w[0]), .busy(busy_w[0])
  );

  cla_adder_pipe #(.WIDTH(16), .STAGES(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_a(in_a[1][15:0]), .in_b(in_b[1][15:0]), .in_cin(in_cin[1]), .in_sub(in_sub[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .out_sum(sum16),
    .out_cout(cout_w[1]), .out_ovf(ovf_w[1]), .out_zero(zero_w[1]), .busy(busy_w[1])
  );

  cla_adder_pipe #(.WIDTH(64), .STAGES(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_cin(in_cin[2]), .in_sub(in_sub[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready[2]), .out_sum(sum64),
    .out_cout(cout_w[2]), .out_ovf(ovf_w[2]), .out_zero(zero_w[2]), .busy(busy_w[2])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 32 : (i == 1) ? 16 : 64;
  endfunction

  function automatic int stg(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 8;
  endfunction

  function automatic logic [63:0] mask(input int w);
    logic [63:0] m;
    m = '1;
    return m >> (64 - w);
  endfunction

  function automatic logic signed [66:0] sext(input logic [63:0] v, input int w);
    logic signed [66:0] t;
    t = $signed({3'b000, v});
    t = t <<< (67 - w);
    t = t >>> (67 - w);
    return t;
  endfunction

  // Reference: unsigned result/borrow from plain arithmetic, overflow from the exact signed result.
  function automatic res_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                 input logic cin, input logic sub);
    res_t               r;
    logic [63:0]        a, b, m;
    logic [64:0]        full;
    logic signed [66:0] sa, sb, sr, lim;
    m = mask(w);
    a = a_in & m;
    b = b_in & m;
    if (sub) begin
      r.s  = (a - b) & m;
      r.co = (a >= b);
      full = '0;
    end else begin
      full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      r.s  = full[63:0] & m;
      r.co = full[w];
    end
    sa   = sext(a, w);
    sb   = sext(b, w);
    sr   = sub ? (sa - sb) : (sa + sb + $signed({66'd0, cin}));
    lim  = 67'sd1 <<< (w - 1);
    r.ov = (sr >= lim) || (sr < -lim);
    r.z  = (r.s == 64'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat(input int i);
    int          w;
    logic [63:0] v [2];
    w = wid(i);
    for (int k = 0; k < 2; k++) begin
      case ($urandom_range(0, 7))
        0:       v[k] = '0;
        1:       v[k] = mask(w);
        2:       v[k] = 64'd1 << (w - 1);
        3:       v[k] = mask(w) >> 1;
        default: v[k] = {$urandom, $urandom} & mask(w);
      endcase
    end
    in_a[i]   = v[0];
    in_b[i]   = v[1];
    in_cin[i] = 1'($urandom_range(0, 1));
    in_sub[i] = 1'($urandom_range(0, 1));
  endtask

  // Scoreboard: every accepted beat must come out once, in order, matching the model.
  initial begin
    for (int i = 0; i < NI; i++) begin
      rx_cnt[i]     = 0;
      stall_prev[i] = 1'b0;
      prev_sum[i]   = '0;
      prev_flg[i]   = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          q[i].delete();
          stall_prev[i] = 1'b0;
        end else begin
          if (stall_prev[i]) begin
            chk($sformatf("hold_valid_i%0d", i), 64'(out_valid_w[i]), 64'd1);
            chk($sformatf("hold_sum_i%0d", i), sum_w[i], prev_sum[i]);
            chk($sformatf("hold_flags_i%0d", i), 64'({cout_w[i], ovf_w[i], zero_w[i]}), 64'(prev_flg[i]));
          end
          if (out_valid_w[i] && out_ready[i]) begin
            chk($sformatf("out_expected_i%0d", i), 64'(q[i].size() != 0), 64'd1);
            if (q[i].size() != 0) begin
              res_t e;
              e = q[i].pop_front();
              chk($sformatf("sum_i%0d", i), sum_w[i], e.s);
              chk($sformatf("cout_i%0d", i), 64'(cout_w[i]), 64'(e.co));
              chk($sformatf("ovf_i%0d", i), 64'(ovf_w[i]), 64'(e.ov));
              chk($sformatf("zero_i%0d", i), 64'(zero_w[i]), 64'(e.z));
            end
            rx_cnt[i]++;
          end
          if (in_valid[i] && in_ready_w[i])
            q[i].push_back(model(wid(i), in_a[i], in_b[i], in_cin[i], in_sub[i]));
          stall_prev[i] = out_valid_w[i] && !out_ready[i];
          prev_sum[i]   = sum_w[i];
          prev_flg[i]   = {cout_w[i], ovf_w[i], zero_w[i]};
        end
      end
    end
  end

  task automatic stream(input int i, input int n, input int mode);
    int   sent, cyc, rx0;
    logic pend;
    sent = 0;
    cyc  = 0;
    pend = 1'b0;
    rx0  = rx_cnt[i];
    while (sent < n && cyc < 2000) begin
      if (!pend) begin
        if (mode == 0 || $urandom_range(0, 3) != 0) begin
          rand_beat(i);
          in_valid[i] = 1'b1;
          pend        = 1'b1;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      out_ready[i] = (mode == 0) ? (((cyc / 2) % 2) == 0) : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid[i] && in_ready_w[i]) begin
        sent++;
        pend = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    cyc = 0;
    while ((rx_cnt[i] - rx0) < n && cyc < 200) begin
      step();
      cyc++;
    end
    chk($sformatf("rx_count_i%0d_m%0d", i, mode), 64'(rx_cnt[i] - rx0), 64'(n));
  endtask

  task automatic rst_mid(input int i);
    int s;
    s = stg(i);
    out_ready[i] = 1'b1;
    for (int j = 0; j < s; j++) begin
      rand_beat(i);
      in_valid[i] = 1'b1;
      if (j == s - 1) rst_n = 1'b0;
      @(negedge clk);
      chk($sformatf("rst_mid_fill_i%0d", i), 64'(out_valid_w[i]), 64'd0);
      step();
    end
    in_valid[i] = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < s + 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_no_out_i%0d", i), 64'(out_valid_w[i]), 64'd0);
      step();
    end
    chk($sformatf("rst_mid_busy_i%0d", i), 64'(busy_w[i]), 64'd0);
  endtask

  initial begin
    vec_t tbl[10];
    int   lat;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      in_a[i]      = '0;
      in_b[i]      = '0;
      in_cin[i]    = 1'b0;
      in_sub[i]    = 1'b0;
      out_ready[i] = 1'b1;
    end

    // Reset held three cycles while a beat is offered: nothing may be captured.
    in_valid[0] = 1'b1;
    rand_beat(0);
    repeat (3) step();
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid_w[0]), 64'd0);
    chk("reset_busy", 64'(busy_w[0]), 64'd0);
    chk("reset_sum", sum_w[0], 64'd0);
    chk("reset_flags", 64'({cout_w[0], ovf_w[0], zero_w[0]}), 64'd0);
    chk("reset_in_ready", 64'(in_ready_w[0]), 64'd1);
    step();

    for (int v = 0; v < 10; v++) begin
      rst_n       = 1'b1;
      in_a[0]     = {32'd0, tbl[v].a};
      in_b[0]     = {32'd0, tbl[v].b};
      in_cin[0]   = tbl[v].cin;
      in_sub[0]   = tbl[v].sub;
      in_valid[0] = 1'b1;
      step();
      in_valid[0] = 1'b0;
      lat = 1;
      while (!out_valid_w[0] && lat < 20) begin
        step();
        lat++;
      end
      chk($sformatf("dir%0d_latency", v), 64'(lat), 64'(stg(0)));
      chk($sformatf("dir%0d_sum", v), sum_w[0], {32'd0, tbl[v].s});
      chk($sformatf("dir%0d_cout", v), 64'(cout_w[0]), 64'(tbl[v].co));
      chk($sformatf("dir%0d_ovf", v), 64'(ovf_w[0]), 64'(tbl[v].ov));
      chk($sformatf("dir%0d_zero", v), 64'(zero_w[0]), 64'(tbl[v].z));
      step();
    end

    for (int i = 0; i < NI; i++) begin
      stream(i, 10, 0);
      stream(i, 60, 1);
      rst_mid(i);
      stream(i, 10, 0);
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
